// File: rtl/alcohol_dispenser_top.sv
// -----------------------------------------------------------------------------
// alcohol_dispenser_top
//
// Four-channel drink dispenser controller. Rising edges on the request buttons
// queue pour requests. Requests are served strictly in arrival order, and one
// pump is driven at a time for POUR_CYCLES clocks. A multiplexed 4-digit
// seven-segment display shows the pouring pump (digit 0) and the queued pumps
// from head to tail (digits 1..3).
//
// Parameters
//   POUR_CYCLES  clocks each pump stays on per request
//   SCAN_CYCLES  clocks each display digit stays selected
//
// Ports
//   clk           in   system clock
//   RESET         in   synchronous, active-high reset
//   load0..load3  in   request buttons (level); a rising edge is one request
//   p0..p3        out  pump enables, active-high, at most one high at a time
//   seg_out       out  segment drive, active-low, {dp,g,f,e,d,c,b,a}
//   digit_select  out  digit enable, active-low one-hot; bit i selects digit i
// -----------------------------------------------------------------------------
module alcohol_dispenser_top #(
    parameter int POUR_CYCLES = 100,
    parameter int SCAN_CYCLES = 4
) (
    input  logic       clk,
    input  logic       RESET,
    input  logic       load0,
    input  logic       load1,
    input  logic       load2,
    input  logic       load3,
    output logic       p0,
    output logic       p1,
    output logic       p2,
    output logic       p3,
    output logic [7:0] seg_out,
    output logic [3:0] digit_select
);

    localparam int PW = $clog2(POUR_CYCLES + 1);
    localparam int SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_POUR = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Numeral N+1 for pump id N, active-low segments.
    function automatic logic [7:0] seg_code(input logic [1:0] id);
        case (id)
            2'd0:    return 8'hF9;
            2'd1:    return 8'hA4;
            2'd2:    return 8'hB0;
            default: return 8'h99;
        endcase
    endfunction

    // Lowest set bit of a 4-bit request vector.
    function automatic logic [1:0] lowest_idx(input logic [3:0] v);
        if (v[0])      return 2'd0;
        else if (v[1]) return 2'd1;
        else if (v[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    // ---------------------------------------------------------------------
    // Input sampling and edge detection
    // ---------------------------------------------------------------------
    logic [3:0] load_cur_q;
    logic [3:0] load_prev_q;
    logic [3:0] edge_w;

    always_ff @(posedge clk) begin
        if (RESET) begin
            load_cur_q  <= 4'b0000;
            load_prev_q <= 4'b0000;
        end else begin
            load_cur_q  <= {load3, load2, load1, load0};
            load_prev_q <= load_cur_q;
        end
    end

    assign edge_w = load_cur_q & ~load_prev_q;

    // ---------------------------------------------------------------------
    // Pending request flags, FIFO and pour FSM state
    // ---------------------------------------------------------------------
    logic [3:0]    req_q, req_d;
    logic [1:0]    fifo_q [4];
    logic [1:0]    fifo_d [4];
    logic [2:0]    cnt_q, cnt_d;
    logic [1:0]    state_q, state_d;
    logic [1:0]    active_q, active_d;
    logic [PW-1:0] pour_cnt_q, pour_cnt_d;

    logic [3:0] queued_mask;
    logic [3:0] active_mask;
    logic [3:0] new_req;
    logic       push_w;
    logic [1:0] push_id;
    logic       pop_w;
    logic [2:0] wr_idx;

    // A pump already anywhere in the pipeline (flag, FIFO, active slot)
    // is not accepted again; this is also what keeps the FIFO from
    // overflowing. The active slot counts until the FSM is back in IDLE.
    always_comb begin
        queued_mask = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (3'(i) < cnt_q) queued_mask[fifo_q[i]] = 1'b1;
        end
        active_mask = 4'b0000;
        if (state_q != ST_IDLE) active_mask[active_q] = 1'b1;
        new_req = edge_w & ~(queued_mask | active_mask | req_q);
    end

    always_comb begin
        push_w  = |req_q;
        push_id = lowest_idx(req_q);
        pop_w   = (state_q == ST_IDLE) && (cnt_q != 3'd0);
    end

    always_comb begin
        req_d = req_q;
        if (push_w) req_d[push_id] = 1'b0;
        req_d = req_d | new_req;
    end

    // Shift-register FIFO: entry 0 is the head. Pop and push may happen in
    // the same cycle, so the write slot is taken after the pop adjustment.
    always_comb begin
        fifo_d = fifo_q;
        cnt_d  = cnt_q;
        wr_idx = cnt_q;
        if (pop_w) begin
            for (int i = 0; i < 3; i++) fifo_d[i] = fifo_q[i+1];
            cnt_d  = cnt_q - 3'd1;
            wr_idx = cnt_q - 3'd1;
        end
        if (push_w) begin
            fifo_d[wr_idx[1:0]] = push_id;
            cnt_d               = cnt_d + 3'd1;
        end
    end

    always_comb begin
        state_d    = state_q;
        active_d   = active_q;
        pour_cnt_d = pour_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pop_w) begin
                    active_d   = fifo_q[0];
                    pour_cnt_d = PW'(POUR_CYCLES);
                    state_d    = ST_POUR;
                end
            end
            ST_POUR: begin
                // Counter starts at POUR_CYCLES, so POUR lasts exactly that
                // many cycles before handing over to the one-cycle GAP.
                if (pour_cnt_q <= PW'(1)) begin
                    state_d = ST_GAP;
                end else begin
                    pour_cnt_d = pour_cnt_q - PW'(1);
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            req_q      <= 4'b0000;
            cnt_q      <= 3'd0;
            state_q    <= ST_IDLE;
            pour_cnt_q <= '0;
        end else begin
            req_q      <= req_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            pour_cnt_q <= pour_cnt_d;
        end
    end

    // FIFO contents and active id are qualified by cnt_q / state_q.
    always_ff @(posedge clk) begin
        fifo_q   <= fifo_d;
        active_q <= active_d;
    end

    // ---------------------------------------------------------------------
    // Display scan and registered outputs
    // ---------------------------------------------------------------------
    logic [SW-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]    dig_q, dig_d;
    logic [7:0]    seg_q, seg_d;
    logic [3:0]    dsel_q;
    logic [3:0]    p_q, p_d;

    always_comb begin
        scan_cnt_d = scan_cnt_q + SW'(1);
        dig_d      = dig_q;
        if (scan_cnt_q == SW'(SCAN_CYCLES - 1)) begin
            scan_cnt_d = '0;
            dig_d      = dig_q + 2'd1;
        end
    end

    // Segment pattern is chosen for the digit being selected at the same
    // edge, so seg_out and digit_select always agree.
    always_comb begin
        seg_d = SEG_BLANK;
        case (dig_d)
            2'd0:    if (state_q == ST_POUR) seg_d = seg_code(active_q);
            2'd1:    if (cnt_q > 3'd0)       seg_d = seg_code(fifo_q[0]);
            2'd2:    if (cnt_q > 3'd1)       seg_d = seg_code(fifo_q[1]);
            default: if (cnt_q > 3'd2)       seg_d = seg_code(fifo_q[2]);
        endcase
    end

    always_comb begin
        p_d = 4'b0000;
        if (state_q == ST_POUR) p_d = 4'b0001 << active_q;
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            scan_cnt_q <= '0;
            dig_q      <= 2'd0;
            seg_q      <= SEG_BLANK;
            dsel_q     <= 4'b1110;
            p_q        <= 4'b0000;
        end else begin
            scan_cnt_q <= scan_cnt_d;
            dig_q      <= dig_d;
            seg_q      <= seg_d;
            dsel_q     <= ~(4'b0001 << dig_d);
            p_q        <= p_d;
        end
    end

    assign p0           = p_q[0];
    assign p1           = p_q[1];
    assign p2           = p_q[2];
    assign p3           = p_q[3];
    assign seg_out      = seg_q;
    assign digit_select = dsel_q;

endmodule

// File: tb/tb_alcohol_dispenser_top.sv
module tb_alcohol_dispenser_top;

    localparam int POUR = 100;
    localparam int SCAN = 4;

    logic       clk = 1'b0;
    logic       RESET;
    logic       load0, load1, load2, load3;
    logic       p0, p1, p2, p3;
    logic [7:0] seg_out;
    logic [3:0] digit_select;

    always #5 clk = ~clk;

    alcohol_dispenser_top #(
        .POUR_CYCLES(POUR),
        .SCAN_CYCLES(SCAN)
    ) dut (
        .clk         (clk),
        .RESET       (RESET),
        .load0       (load0),
        .load1       (load1),
        .load2       (load2),
        .load3       (load3),
        .p0          (p0),
        .p1          (p1),
        .p2          (p2),
        .p3          (p3),
        .seg_out     (seg_out),
        .digit_select(digit_select)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [3:0] pv;
    logic [3:0] prev_pv = 4'b0000;
    int pour_id    [16];
    int pour_start [16];
    int pour_len   [16];
    int npours    = 0;
    int cur_start = 0;

    int e0;
    int n0;
    int seg_seen;
    logic [3:0] exp_ds;
    logic [7:0] exp_seg;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample after the edge, check pump exclusivity, log pours.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        pv = {p3, p2, p1, p0};
        chk("pump_onehot", 32'($countones(pv) <= 1), 32'd1);
        if (pv != prev_pv) begin
            if (prev_pv != 4'b0000 && npours > 0) pour_len[npours-1] = cyc - cur_start;
            if (pv != 4'b0000 && npours < 16) begin
                pour_id[npours]    = pv[0] ? 0 : pv[1] ? 1 : pv[2] ? 2 : 3;
                pour_start[npours] = cyc;
                cur_start          = cyc;
                npours++;
            end
        end
        prev_pv = pv;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        // Reset with every button held high.
        RESET = 1'b1;
        load0 = 1'b1; load1 = 1'b1; load2 = 1'b1; load3 = 1'b1;
        tick();
        tick();
        chk("reset_p",    32'({p3, p2, p1, p0}), 32'h0);
        chk("reset_dsel", 32'(digit_select),     32'hE);
        chk("reset_seg",  32'(seg_out),          32'hFF);

        // Release; scan rotation on an empty system.
        RESET = 1'b0;
        load0 = 1'b0; load1 = 1'b0; load2 = 1'b0; load3 = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            exp_ds = ~(4'b0001 << ((k / 4) % 4));
            chk("scan_dsel",  32'(digit_select), 32'(exp_ds));
            chk("scan_blank", 32'(seg_out),      32'hFF);
        end
        ticks(4);
        chk("no_pour_after_reset", 32'(npours), 32'd0);

        // Single request, load3 held for 126 cycles.
        n0 = npours;
        load3 = 1'b1;
        e0 = cyc + 1;
        seg_seen = 0;
        for (int i = 0; i < 126; i++) begin
            tick();
            if (p3 && digit_select == 4'b1110) begin
                chk("digit0_pour", 32'(seg_out), 32'h99);
                seg_seen++;
            end
        end
        load3 = 1'b0;
        ticks(10);
        chk("single_count", 32'(npours - n0),    32'd1);
        chk("single_id",    32'(pour_id[n0]),    32'd3);
        chk("single_start", 32'(pour_start[n0]), 32'(e0 + 4));
        chk("single_len",   32'(pour_len[n0]),   32'(POUR));
        chk("digit0_seen",  32'(seg_seen > 0),   32'd1);

        // Ordering: 3, then 1 during the pour, then 0 and 2 two cycles apart.
        n0 = npours;
        load3 = 1'b1;
        e0 = cyc + 1;
        ticks(10);
        load1 = 1'b1;
        ticks(2);
        load0 = 1'b1;
        ticks(2);
        load2 = 1'b1;
        ticks(6);
        for (int i = 0; i < 16; i++) begin
            tick();
            case (digit_select)
                4'b1110: exp_seg = 8'h99;
                4'b1101: exp_seg = 8'hA4;
                4'b1011: exp_seg = 8'hF9;
                4'b0111: exp_seg = 8'hB0;
                default: exp_seg = 8'h00;
            endcase
            chk("queue_display", 32'(seg_out), 32'(exp_seg));
        end
        load0 = 1'b0; load1 = 1'b0; load2 = 1'b0; load3 = 1'b0;
        ticks(420);
        chk("order_count", 32'(npours - n0),     32'd4);
        chk("order_id0",   32'(pour_id[n0]),     32'd3);
        chk("order_id1",   32'(pour_id[n0+1]),   32'd1);
        chk("order_id2",   32'(pour_id[n0+2]),   32'd0);
        chk("order_id3",   32'(pour_id[n0+3]),   32'd2);
        chk("order_start", 32'(pour_start[n0]),  32'(e0 + 4));
        for (int j = 0; j < 4; j++) begin
            chk("order_len", 32'(pour_len[n0+j]), 32'(POUR));
        end
        for (int j = 0; j < 3; j++) begin
            chk("order_gap", 32'(pour_start[n0+j+1] - (pour_start[n0+j] + pour_len[n0+j])), 32'd2);
        end

        // Duplicates: load1 pressed repeatedly while pump 1 is queued.
        n0 = npours;
        load0 = 1'b1;
        ticks(6);
        load1 = 1'b1;
        ticks(3);
        load1 = 1'b0;
        ticks(2);
        load1 = 1'b1;
        ticks(2);
        load1 = 1'b0;
        ticks(2);
        load1 = 1'b1;
        ticks(2);
        load1 = 1'b0;
        load0 = 1'b0;
        ticks(250);
        chk("dup_count", 32'(npours - n0),   32'd2);
        chk("dup_id0",   32'(pour_id[n0]),   32'd0);
        chk("dup_id1",   32'(pour_id[n0+1]), 32'd1);

        // One-cycle pulse on load1 after pump 1 finished: second pour.
        load1 = 1'b1;
        e0 = cyc + 1;
        tick();
        load1 = 1'b0;
        ticks(120);
        chk("repeat_count", 32'(npours - n0),     32'd3);
        chk("repeat_id",    32'(pour_id[n0+2]),   32'd1);
        chk("repeat_start", 32'(pour_start[n0+2]), 32'(e0 + 4));
        chk("repeat_len",   32'(pour_len[n0+2]),  32'(POUR));

        // Simultaneous edges on load2 and load0.
        n0 = npours;
        load0 = 1'b1;
        load2 = 1'b1;
        e0 = cyc + 1;
        ticks(2);
        load0 = 1'b0;
        load2 = 1'b0;
        ticks(220);
        chk("simul_count",  32'(npours - n0),      32'd2);
        chk("simul_id0",    32'(pour_id[n0]),      32'd0);
        chk("simul_id1",    32'(pour_id[n0+1]),    32'd2);
        chk("simul_start0", 32'(pour_start[n0]),   32'(e0 + 4));
        chk("simul_start1", 32'(pour_start[n0+1]), 32'(e0 + 106));
        chk("simul_len0",   32'(pour_len[n0]),     32'(POUR));
        chk("simul_len1",   32'(pour_len[n0+1]),   32'(POUR));

        // Reset in the middle of a pour with another pump queued.
        load3 = 1'b1;
        tick();
        load3 = 1'b0;
        ticks(19);
        load1 = 1'b1;
        tick();
        load1 = 1'b0;
        ticks(5);
        chk("mid_pour_p3", 32'(p3), 32'd1);
        RESET = 1'b1;
        tick();
        chk("midreset_p",    32'({p3, p2, p1, p0}), 32'h0);
        chk("midreset_dsel", 32'(digit_select),     32'hE);
        chk("midreset_seg",  32'(seg_out),          32'hFF);
        RESET = 1'b0;
        n0 = npours;
        ticks(150);
        chk("queue_discarded", 32'(npours - n0),      32'd0);
        chk("idle_p",          32'({p3, p2, p1, p0}), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
